plic_target_arb: RTL and testbench

PLIC_TARGET_ARB -- requirements
Module: plic_target_arb

---
 rtl/plic_pkg.sv | 30 +++
 rtl/plic_target_arb_if.sv | 30 +++
 rtl/plic_prio_cmp.sv | 13 +
 rtl/plic_target_arb.sv | 188 ++++++++++++++++++
 tb/tb_plic_target_arb.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/plic_pkg.sv
// Shared PLIC types: priority width, source-count ceiling, 5-bit ID typedefs
// and the {id, prio} candidate passed through the arbitration compare.
package plic_pkg;

  localparam int PRIO_W  = 3;
  localparam int MAX_SRC = 32;

  typedef logic [4:0]        src_id_t;
  typedef logic [4:0]        tgt_id_t;
  typedef logic [PRIO_W-1:0] prio_t;

  typedef struct packed {
    src_id_t id;
    prio_t   prio;
  } cand_t;

  // Non-eligible or zero-priority sources collapse to the empty candidate {0,0}.
  function automatic cand_t make_cand(input logic eligible, input src_id_t id, input prio_t prio);
    cand_t c;
    if (eligible && (prio != {PRIO_W{1'b0}})) begin
      c.id   = id;
      c.prio = prio;
    end else begin
      c.id   = 5'd0;
      c.prio = {PRIO_W{1'b0}};
    end
    return c;
  endfunction

endpackage

// File: rtl/plic_target_arb_if.sv
// Claim/complete register-access bus between a hart context and its PLIC
// target arbiter, including the broadcasts back toward the gateways.
interface plic_target_arb_if;
  import plic_pkg::*;

  logic    claim_req;
  logic    claim_ack;
  src_id_t claim_id;
  logic    claim_valid;
  src_id_t claim_src;
  tgt_id_t claim_tgt;
  logic    complete_req;
  src_id_t complete_id;
  logic    complete_valid;
  src_id_t complete_src;
  tgt_id_t complete_tgt;

  modport master (
    output claim_req, complete_req, complete_id,
    input  claim_ack, claim_id, claim_valid, claim_src, claim_tgt,
    input  complete_valid, complete_src, complete_tgt
  );

  modport slave (
    input  claim_req, complete_req, complete_id,
    output claim_ack, claim_id, claim_valid, claim_src, claim_tgt,
    output complete_valid, complete_src, complete_tgt
  );

endinterface

// File: rtl/plic_prio_cmp.sv
// Priority compare-select: the challenger wins only on strictly greater
// priority, so feeding the lower ID as incumbent resolves ties to the lower ID.
module plic_prio_cmp
  import plic_pkg::*;
(
  input  cand_t inc,
  input  cand_t chal,
  output cand_t win
);

  assign win = (chal.prio > inc.prio) ? chal : inc;

endmodule

// File: rtl/plic_target_arb.sv
// PLIC per-target arbiter: finds the highest-priority enabled pending source,
// raises irq above threshold and serves claim/complete accesses.
// Build option PLIC_PARALLEL_ARB_EN replaces the one-source-per-cycle scanner
// with a single-cycle combinational priority tree.
module plic_target_arb
  import plic_pkg::*;
#(
  parameter int      NUM_SRC = 32,
  parameter tgt_id_t TGT_ID  = 5'd0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        int_pending,
  input  logic [NUM_SRC-1:0]        src_en,
  input  logic [NUM_SRC*PRIO_W-1:0] src_prio,
  input  prio_t                     threshold,
  output logic                      irq,
  plic_target_arb_if.slave          bus
);

  localparam src_id_t    LAST_IDX  = src_id_t'(NUM_SRC - 1);
  localparam logic [5:0] NUM_SRC_W = 6'(NUM_SRC);

  // Widen to the architectural maximum so a 5-bit ID can index directly.
  logic [MAX_SRC-1:0]        pend_full_s;
  logic [MAX_SRC-1:0]        en_full_s;
  logic [MAX_SRC*PRIO_W-1:0] prio_full_s;

  assign pend_full_s = MAX_SRC'(int_pending);
  assign en_full_s   = MAX_SRC'(src_en);
  assign prio_full_s = (MAX_SRC*PRIO_W)'(src_prio);

  cand_t commit_s;
  logic  commit_en_s;
  cand_t max_r;
  cand_t max_next_s;
  logic  irq_r;
  logic  recheck_ok_s;
  logic  cmp_ok_s;

  logic    claim_ack_r;
  src_id_t claim_id_r;
  logic    claim_valid_r;
  src_id_t claim_src_r;
  tgt_id_t claim_tgt_r;
  logic    complete_valid_r;
  src_id_t complete_src_r;
  tgt_id_t complete_tgt_r;

`ifdef PLIC_PARALLEL_ARB_EN
  cand_t lvl0_s [MAX_SRC];
  cand_t lvl1_s [16];
  cand_t lvl2_s [8];
  cand_t lvl3_s [4];
  cand_t lvl4_s [2];
  cand_t root_s;

  for (genvar i = 0; i < MAX_SRC; i++) begin : g_leaf
    if (i == 0) begin : g_rsvd
      assign lvl0_s[i] = make_cand(1'b0, 5'd0, {PRIO_W{1'b0}});
    end else begin : g_src
      assign lvl0_s[i] = make_cand(pend_full_s[i] & en_full_s[i], src_id_t'(i),
                                   prio_full_s[i*PRIO_W +: PRIO_W]);
    end
  end

  // Even (lower-ID) input is always the incumbent at every tree node.
  for (genvar i = 0; i < 16; i++) begin : g_l1
    plic_prio_cmp u_cmp (.inc(lvl0_s[2*i]), .chal(lvl0_s[2*i+1]), .win(lvl1_s[i]));
  end
  for (genvar i = 0; i < 8; i++) begin : g_l2
    plic_prio_cmp u_cmp (.inc(lvl1_s[2*i]), .chal(lvl1_s[2*i+1]), .win(lvl2_s[i]));
  end
  for (genvar i = 0; i < 4; i++) begin : g_l3
    plic_prio_cmp u_cmp (.inc(lvl2_s[2*i]), .chal(lvl2_s[2*i+1]), .win(lvl3_s[i]));
  end
  for (genvar i = 0; i < 2; i++) begin : g_l4
    plic_prio_cmp u_cmp (.inc(lvl3_s[2*i]), .chal(lvl3_s[2*i+1]), .win(lvl4_s[i]));
  end
  plic_prio_cmp u_root (.inc(lvl4_s[0]), .chal(lvl4_s[1]), .win(root_s));

  assign commit_s    = root_s;
  assign commit_en_s = 1'b1;
`else
  src_id_t idx_r;
  cand_t   best_r;
  cand_t   scan_leaf_s;
  cand_t   scan_win_s;

  assign scan_leaf_s = make_cand(pend_full_s[idx_r] & en_full_s[idx_r], idx_r,
                                 prio_full_s[idx_r*PRIO_W +: PRIO_W]);

  plic_prio_cmp u_scan_cmp (.inc(best_r), .chal(scan_leaf_s), .win(scan_win_s));

  // Scan index and running-best accumulator; a claim restarts the sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r  <= 5'd1;
      best_r <= '0;
    end else if (bus.claim_req || (idx_r == LAST_IDX)) begin
      idx_r  <= 5'd1;
      best_r <= '0;
    end else begin
      idx_r  <= idx_r + 5'd1;
      best_r <= scan_win_s;
    end
  end

  assign commit_s    = scan_win_s;
  assign commit_en_s = (idx_r == LAST_IDX);
`endif

  // Next arbitration result: a claim wipes it, otherwise take any new commit.
  always_comb begin
    max_next_s = max_r;
    if (bus.claim_req) begin
      max_next_s = '0;
    end else if (commit_en_s) begin
      max_next_s = commit_s;
    end else begin
      max_next_s = max_r;
    end
  end

  // Winner register and irq; irq is formed from the value being committed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_r <= '0;
      irq_r <= 1'b0;
    end else begin
      max_r <= max_next_s;
      irq_r <= (max_next_s.id != 5'd0) && (max_next_s.prio > threshold);
    end
  end

  // The winner may have dropped since it was committed, so re-check it live.
  assign recheck_ok_s = (max_r.id != 5'd0) && pend_full_s[max_r.id] &&
                        en_full_s[max_r.id] && (max_r.prio > threshold);

  assign cmp_ok_s = bus.complete_req && (bus.complete_id != 5'd0) &&
                    ({1'b0, bus.complete_id} < NUM_SRC_W);

  // Claim response and claim broadcast.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      claim_ack_r   <= 1'b0;
      claim_id_r    <= 5'd0;
      claim_valid_r <= 1'b0;
      claim_src_r   <= 5'd0;
      claim_tgt_r   <= 5'd0;
    end else if (bus.claim_req) begin
      claim_ack_r   <= 1'b1;
      claim_id_r    <= recheck_ok_s ? max_r.id : 5'd0;
      claim_valid_r <= recheck_ok_s;
      claim_src_r   <= recheck_ok_s ? max_r.id : 5'd0;
      claim_tgt_r   <= TGT_ID;
    end else begin
      claim_ack_r   <= 1'b0;
      claim_valid_r <= 1'b0;
    end
  end

  // Completion broadcast; out-of-range IDs are dropped silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      complete_valid_r <= 1'b0;
      complete_src_r   <= 5'd0;
      complete_tgt_r   <= 5'd0;
    end else if (cmp_ok_s) begin
      complete_valid_r <= 1'b1;
      complete_src_r   <= bus.complete_id;
      complete_tgt_r   <= TGT_ID;
    end else begin
      complete_valid_r <= 1'b0;
    end
  end

  assign irq                = irq_r;
  assign bus.claim_ack      = claim_ack_r;
  assign bus.claim_id       = claim_id_r;
  assign bus.claim_valid    = claim_valid_r;
  assign bus.claim_src      = claim_src_r;
  assign bus.claim_tgt      = claim_tgt_r;
  assign bus.complete_valid = complete_valid_r;
  assign bus.complete_src   = complete_src_r;
  assign bus.complete_tgt   = complete_tgt_r;

endmodule

// File: tb/tb_plic_target_arb.sv
// Self-checking bench for plic_target_arb: directed scenarios plus randomized
// source sets compared with a max-priority/lowest-ID reference model.
module tb_plic_target_arb;
  import plic_pkg::*;

  localparam int      NS  = 16;
  localparam tgt_id_t TGT = 5'd21;
  localparam int      LAT = 2*(NS-1)+1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NS-1:0]        pend;
  logic [NS-1:0]        en;
  logic [NS*PRIO_W-1:0] prio;
  prio_t                thr;
  logic                 irq;
  int                   checks = 0;
  int                   errors = 0;

  plic_target_arb_if bus();

  plic_target_arb #(.NUM_SRC(NS), .TGT_ID(TGT)) dut (
    .clk        (clk),
    .rst        (rst),
    .int_pending(pend),
    .src_en     (en),
    .src_prio   (prio),
    .threshold  (thr),
    .irq        (irq),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: highest priority among eligible sources, first (lowest) ID wins ties.
  function automatic int model_win();
    int best = 0;
    int bp   = 0;
    for (int i = 1; i < NS; i++) begin
      if (pend[i] && en[i] && (int'(prio[i*PRIO_W +: PRIO_W]) > bp)) begin
        best = i;
        bp   = int'(prio[i*PRIO_W +: PRIO_W]);
      end
    end
    return best;
  endfunction

  function automatic logic model_irq();
    int w = model_win();
    return (w != 0) && (int'(prio[w*PRIO_W +: PRIO_W]) > int'(thr));
  endfunction

  task automatic clear_srcs();
    pend = '0;
    en   = '0;
    prio = '0;
  endtask

  task automatic set_src(input int i, input int p);
    pend[i] = 1'b1;
    en[i]   = 1'b1;
    prio[i*PRIO_W +: PRIO_W] = prio_t'(p);
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (!irq && (n < LAT)) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(irq), 32'd1);
  endtask

  task automatic claim(input string tag, input int exp_id);
    bus.claim_req = 1'b1;
    tick();
    bus.claim_req = 1'b0;
    check_eq({tag, "_ack"}, 32'(bus.claim_ack), 32'd1);
    check_eq({tag, "_id"}, 32'(bus.claim_id), 32'(exp_id));
    check_eq({tag, "_valid"}, 32'(bus.claim_valid), 32'(exp_id != 0));
    if (exp_id != 0) begin
      check_eq({tag, "_src"}, 32'(bus.claim_src), 32'(exp_id));
      check_eq({tag, "_tgt"}, 32'(bus.claim_tgt), 32'(TGT));
    end
  endtask

  task automatic complete(input string tag, input int id, input logic exp_valid);
    bus.complete_req = 1'b1;
    bus.complete_id  = src_id_t'(id);
    tick();
    bus.complete_req = 1'b0;
    check_eq({tag, "_valid"}, 32'(bus.complete_valid), 32'(exp_valid));
    if (exp_valid) begin
      check_eq({tag, "_src"}, 32'(bus.complete_src), 32'(id));
      check_eq({tag, "_tgt"}, 32'(bus.complete_tgt), 32'(TGT));
    end
  endtask

  initial begin
    logic [63:0] r64;
    logic        seen;
    int          n;
    int          exp_id;

    rst = 1'b1;
    clear_srcs();
    thr = 3'd0;
    bus.claim_req    = 1'b0;
    bus.complete_req = 1'b0;
    bus.complete_id  = 5'd0;
    tick();
    tick();
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_ack", 32'(bus.claim_ack), 32'd0);
    check_eq("rst_cid", 32'(bus.claim_id), 32'd0);
    check_eq("rst_cvalid", 32'(bus.claim_valid), 32'd0);
    check_eq("rst_pvalid", 32'(bus.complete_valid), 32'd0);
    rst = 1'b0;

    // Single source above threshold.
    thr = 3'd1;
    set_src(3, 2);
    wait_irq("t1_irq");
    claim("t1_claim", 3);
    check_eq("t1_irq_clr", 32'(irq), 32'd0);
    tick();
    check_eq("t1_ack_pulse", 32'(bus.claim_ack), 32'd0);
    check_eq("t1_valid_pulse", 32'(bus.claim_valid), 32'd0);

    // Equal priorities resolve to the lower ID; completing it exposes the other.
    clear_srcs();
    set_src(4, 5);
    set_src(7, 5);
    wait_irq("t2_irq");
    claim("t2_claim_a", 4);
    pend[4] = 1'b0;
    complete("t2_cmp4", 4, 1'b1);
    tick();
    check_eq("t2_cmp_pulse", 32'(bus.complete_valid), 32'd0);
    wait_irq("t2_irq_b");
    claim("t2_claim_b", 7);

    // Priority equal to threshold never interrupts.
    clear_srcs();
    thr = 3'd2;
    set_src(5, 2);
    seen = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      tick();
      seen = seen | irq;
    end
    check_eq("t3_irq_quiet", 32'(seen), 32'd0);
    claim("t3_claim", 0);

    // Pending drops just before the claim.
    clear_srcs();
    thr = 3'd0;
    set_src(6, 3);
    wait_irq("t4_irq");
    pend[6] = 1'b0;
    tick();
    claim("t4_claim", 0);

    // Completion ID range.
    complete("t5_id0", 0, 1'b0);
    complete("t5_id9", 9, 1'b1);
    complete("t5_id15", 15, 1'b1);
    complete("t5_id16", 16, 1'b0);
    complete("t5_id31", 31, 1'b0);

    // Claim and complete in the same cycle.
    clear_srcs();
    set_src(2, 4);
    wait_irq("t6_irq");
    bus.claim_req    = 1'b1;
    bus.complete_req = 1'b1;
    bus.complete_id  = 5'd2;
    tick();
    bus.claim_req    = 1'b0;
    bus.complete_req = 1'b0;
    check_eq("t6_cid", 32'(bus.claim_id), 32'd2);
    check_eq("t6_cvalid", 32'(bus.claim_valid), 32'd1);
    check_eq("t6_pvalid", 32'(bus.complete_valid), 32'd1);
    check_eq("t6_psrc", 32'(bus.complete_src), 32'd2);

    // Reset mid-sweep and mid-claim.
    clear_srcs();
    set_src(2, 1);
    wait_irq("t7_irq");
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_eq("t7_irq_async", 32'(irq), 32'd0);
    bus.claim_req    = 1'b1;
    bus.complete_req = 1'b1;
    bus.complete_id  = 5'd9;
    tick();
    bus.claim_req    = 1'b0;
    bus.complete_req = 1'b0;
    check_eq("t7_ack_in_rst", 32'(bus.claim_ack), 32'd0);
    tick();
    rst  = 1'b0;
    seen = 1'b0;
    n    = 0;
    while (!irq && (n < LAT)) begin
      tick();
      n++;
      seen = seen | bus.claim_valid | bus.complete_valid | bus.claim_ack;
    end
    check_eq("t7_irq_again", 32'(irq), 32'd1);
    check_eq("t7_no_pulse", 32'(seen), 32'd0);

    // Randomized source sets against the reference model.
    for (int t = 0; t < 24; t++) begin
      r64  = {$urandom(), $urandom()};
      pend = NS'($urandom());
      en   = NS'($urandom());
      prio = r64[NS*PRIO_W-1:0];
      thr  = prio_t'($urandom_range(0, 7));
      for (int i = 0; i < LAT; i++) begin
        tick();
      end
      check_eq($sformatf("rnd%0d_irq", t), 32'(irq), 32'(model_irq()));
      exp_id = model_irq() ? model_win() : 0;
      claim($sformatf("rnd%0d", t), exp_id);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
